// File: rtl/tongbu_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through reads and sticky error flags.
module tongbu_fifo #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tongbu_fifo: DEPTH (%0d) must be a power of two >= 2", DEPTH);
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("tongbu_fifo: AFULL_TH (%0d) must be in 1..DEPTH", AFULL_TH);
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("tongbu_fifo: AEMPTY_TH (%0d) must be in 0..DEPTH-1", AEMPTY_TH);
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("tongbu_fifo: DATA_W (%0d) must be >= 1", DATA_W);
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;
  logic          wr_acc,   rd_acc;

  // Status flags decode registered occupancy only, so no request input
  // reaches them combinationally.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AFULL_TH));
  assign almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // NOTE: every variable driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    wr_acc   = wr_en & ~full;
    rd_acc   = rd_en & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A fresh error at the same edge as err_clr wins.
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_en && full)  ovf_d = 1'b1;
    if (rd_en && empty) udf_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define what is valid, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_q] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is visible as soon as it is stored; meaningless while empty.
    assign dout = mem[rd_ptr_q];
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (rst)         dout_q <= '0;
      else if (rd_acc) dout_q <= mem[rd_ptr_q];
    end

    assign dout = dout_q;
  end

endmodule

// File: tb/tb_tongbu_fifo.sv
// Self-checking bench for tongbu_fifo: a standard-mode and an FWFT-mode
// instance share stimulus and are compared against a queue-based model.
module tb_tongbu_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int AFT    = 14;
  localparam int AET    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic              err_clr = 1'b0;
  logic [DATA_W-1:0] din = '0;

  logic [DATA_W-1:0] dout_s, dout_f;
  logic              full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
  logic              full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [4:0]        count_s, count_f;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, standard-mode output register, flags.
  logic [DATA_W-1:0] mq [$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_ovf = 1'b0;
  logic              m_udf = 1'b0;

  always #5 clk = ~clk;

  tongbu_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout_s),
    .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
    .count(count_s), .overflow(ovf_s), .underflow(udf_s), .err_clr(err_clr)
  );

  tongbu_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout_f),
    .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .count(count_f), .overflow(ovf_f), .underflow(udf_f), .err_clr(err_clr)
  );

  task automatic model_step(input logic w, input logic [DATA_W-1:0] d, input logic r,
                            input logic c, input logic rs);
    bit was_full, was_empty;
    if (rs) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (c) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      if (r && !was_empty) m_dout = mq.pop_front();
      if (w && !was_full)  mq.push_back(d);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model, settle.
  task automatic tick(input logic w, input logic [DATA_W-1:0] d, input logic r,
                      input logic c = 1'b0, input logic rs = 1'b0);
    wr_en = w; din = d; rd_en = r; err_clr = c; rst = rs;
    @(posedge clk);
    model_step(w, d, r, c, rs);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (count_s !== 5'd0 || empty_s !== 1'b1 || full_s !== 1'b0 || ae_s !== 1'b1 || af_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: count=%0d empty=%b full=%b ae=%b af=%b, want 0 1 0 1 0",
               count_s, empty_s, full_s, ae_s, af_s);
    end
    checks++;
    if (ovf_s !== 1'b0 || udf_s !== 1'b0 || dout_s !== 16'h0000 || count_f !== 5'd0 || empty_f !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: ovf=%b udf=%b dout=%h fw_count=%0d fw_empty=%b, want 0 0 0000 0 1",
               ovf_s, udf_s, dout_s, count_f, empty_f);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 20; i++) begin
      int n;
      tick(1'b1, DATA_W'(i), 1'b0);
      n = (i + 1 > DEPTH) ? DEPTH : i + 1;
      checks++;
      if (count_s !== 5'(n) || ae_s !== (i + 1 <= AET) || af_s !== (i + 1 >= AFT) ||
          full_s !== (i + 1 >= DEPTH) || ovf_s !== (i + 1 > DEPTH) || count_f !== 5'(n)) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d ae=%b af=%b full=%b ovf=%b fw_count=%0d, want %0d %b %b %b %b",
                 i, count_s, ae_s, af_s, full_s, ovf_s, count_f, n,
                 (i + 1 <= AET), (i + 1 >= AFT), (i + 1 >= DEPTH), (i + 1 > DEPTH));
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (dout_f !== DATA_W'(i)) begin
        errors++;
        $display("FAIL fwft_head_%0d: dout=%h want %h", i, dout_f, DATA_W'(i));
      end
      tick(1'b0, '0, 1'b1);
      checks++;
      if (dout_s !== DATA_W'(i)) begin
        errors++;
        $display("FAIL drain_%0d: dout=%h want %h", i, dout_s, DATA_W'(i));
      end
    end
    checks++;
    if (empty_s !== 1'b1 || count_s !== 5'd0 || udf_s !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: empty=%b count=%0d udf=%b, want 1 0 0", empty_s, count_s, udf_s);
    end
    tick(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) tick(1'b1, DATA_W'(16'h0050 + i), 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) tick(1'b1, DATA_W'(16'h0100 + i), 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, '0, 1'b1);
      checks++;
      if (dout_s !== DATA_W'(16'h0100 + i)) begin
        errors++;
        $display("FAIL wrap_%0d: dout=%h want %h", i, dout_s, DATA_W'(16'h0100 + i));
      end
    end
    checks++;
    if (count_s !== 5'd0 || empty_s !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end: count=%0d empty=%b, want 0 1", count_s, empty_s);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, DATA_W'(16'h0200 + i), 1'b0);
    tick(1'b1, 16'hDEAD, 1'b1);
    checks++;
    if (count_s !== 5'd15 || dout_s !== 16'h0200) begin
      errors++;
      $display("FAIL simul_full: count=%0d dout=%h, want 15 0200", count_s, dout_s);
    end
    for (int i = 1; i < DEPTH; i++) begin
      tick(1'b0, '0, 1'b1);
      checks++;
      if (dout_s !== DATA_W'(16'h0200 + i)) begin
        errors++;
        $display("FAIL simul_full_drain_%0d: dout=%h want %h", i, dout_s, DATA_W'(16'h0200 + i));
      end
    end
    tick(1'b1, 16'h0077, 1'b1);
    checks++;
    if (count_s !== 5'd1 || dout_s !== 16'h020F || dout_f !== 16'h0077 || udf_s !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty: count=%0d dout=%h fw_dout=%h udf=%b, want 1 020f 0077 1",
               count_s, dout_s, dout_f, udf_s);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, DATA_W'(16'h0300 + i), 1'b0);
    tick(1'b1, 16'h0399, 1'b1);
    checks++;
    if (count_s !== 5'd5 || dout_s !== 16'h0077) begin
      errors++;
      $display("FAIL simul_mid: count=%0d dout=%h, want 5 0077", count_s, dout_s);
    end
    for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b1);
    checks++;
    if (dout_s !== 16'h0399 || empty_s !== 1'b1) begin
      errors++;
      $display("FAIL simul_mid_tail: dout=%h empty=%b, want 0399 1", dout_s, empty_s);
    end
    tick(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_fwft();
    tick(1'b1, 16'hA5A5, 1'b0);
    checks++;
    if (empty_f !== 1'b0 || dout_f !== 16'hA5A5 || dout_s !== 16'h0399) begin
      errors++;
      $display("FAIL fwft_write: fw_empty=%b fw_dout=%h std_dout=%h, want 0 a5a5 0399",
               empty_f, dout_f, dout_s);
    end
    tick(1'b0, '0, 1'b1);
    checks++;
    if (empty_f !== 1'b1 || count_f !== 5'd0 || dout_s !== 16'hA5A5) begin
      errors++;
      $display("FAIL fwft_pop: fw_empty=%b fw_count=%0d std_dout=%h, want 1 0 a5a5",
               empty_f, count_f, dout_s);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, DATA_W'(16'h0400 + i), 1'b0);
    tick(1'b0, '0, 1'b1);
    tick(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    checks++;
    if (count_s !== 5'd0 || empty_s !== 1'b1 || dout_s !== 16'h0000 || udf_s !== 1'b0 ||
        ovf_s !== 1'b0 || count_f !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: count=%0d empty=%b dout=%h udf=%b ovf=%b fw_count=%0d, want 0 1 0000 0 0 0",
               count_s, empty_s, dout_s, udf_s, ovf_s, count_f);
    end
    tick(1'b1, 16'h0033, 1'b0);
    checks++;
    if (dout_f !== 16'h0033 || count_s !== 5'd1) begin
      errors++;
      $display("FAIL reset_mid_fwft: fw_dout=%h count=%0d, want 0033 1", dout_f, count_s);
    end
    tick(1'b0, '0, 1'b1);
    checks++;
    if (dout_s !== 16'h0033 || empty_s !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_read: dout=%h empty=%b, want 0033 1", dout_s, empty_s);
    end
  endtask

  task automatic test_underflow();
    tick(1'b0, '0, 1'b1);
    checks++;
    if (udf_s !== 1'b1 || count_s !== 5'd0 || dout_s !== 16'h0033 || udf_f !== 1'b1) begin
      errors++;
      $display("FAIL underflow_set: udf=%b count=%0d dout=%h fw_udf=%b, want 1 0 0033 1",
               udf_s, count_s, dout_s, udf_f);
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (udf_s !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clr: udf=%b want 0", udf_s);
    end
    tick(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (udf_s !== 1'b1) begin
      errors++;
      $display("FAIL underflow_clr_race: udf=%b want 1", udf_s);
    end
    for (int i = 0; i < DEPTH; i++) tick(1'b1, DATA_W'(i), 1'b0);
    tick(1'b1, 16'hBEEF, 1'b0, 1'b1);
    checks++;
    if (ovf_s !== 1'b1 || udf_s !== 1'b0 || count_s !== 5'd16) begin
      errors++;
      $display("FAIL overflow_clr_race: ovf=%b udf=%b count=%0d, want 1 0 16", ovf_s, udf_s, count_s);
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (ovf_s !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clr: ovf=%b want 0", ovf_s);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      int wp, rp, sz;
      wp = ((n / 300) % 2 == 0) ? 70 : 35;
      rp = 100 - wp;
      tick($urandom_range(0, 99) < wp, DATA_W'($urandom), $urandom_range(0, 99) < rp,
           $urandom_range(0, 99) < 5, $urandom_range(0, 999) < 3);
      sz = mq.size();
      checks++;
      if (count_s !== 5'(sz) || full_s !== (sz == DEPTH) || empty_s !== (sz == 0) ||
          af_s !== (sz >= AFT) || ae_s !== (sz <= AET) || ovf_s !== m_ovf || udf_s !== m_udf ||
          dout_s !== m_dout) begin
        errors++;
        $display("FAIL rand_std_%0d: count=%0d full=%b empty=%b af=%b ae=%b ovf=%b udf=%b dout=%h, want %0d %b %b %b %b %b %b %h",
                 n, count_s, full_s, empty_s, af_s, ae_s, ovf_s, udf_s, dout_s,
                 sz, (sz == DEPTH), (sz == 0), (sz >= AFT), (sz <= AET), m_ovf, m_udf, m_dout);
      end
      checks++;
      if (count_f !== 5'(sz) || ovf_f !== m_ovf || udf_f !== m_udf || (sz > 0 && dout_f !== mq[0])) begin
        errors++;
        $display("FAIL rand_fwft_%0d: count=%0d ovf=%b udf=%b dout=%h, want %0d %b %b %h",
                 n, count_f, ovf_f, udf_f, dout_f, sz, m_ovf, m_udf, (sz > 0) ? mq[0] : dout_f);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_fwft();
    test_reset_mid();
    test_underflow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tongbu_fifo.md
Name: tongbu_fifo

Overview:
Single-clock, parametrised FIFO and the synchronous successor to the team's dual-clock FIFO. It is used where producer and consumer share one clock domain. Over a plain FIFO it adds an occupancy count, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.

Parameters:
DATA_W, 16, data word width in bits (>=1).
DEPTH, 16, number of entries; power of two, >=2.
AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  write request.
din  in  DATA_W  write data.
rd_en  in  1  read/pop request.
dout  out  DATA_W  read data.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AFULL_TH.
almost_empty  out  1  count <= AEMPTY_TH.
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky flag: a write was attempted while full.
underflow  out  1  sticky flag: a read was attempted while empty.
err_clr  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst=1 at an edge; overrides every other input):
  - wr_ptr, rd_ptr, count = 0; dout = 0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (with AFULL_TH >= 1).
  - overflow=0, underflow=0.
  - Memory contents are not reset. Reset mid-operation discards all stored data.
- Acceptance rules, evaluated on pre-edge state:
  - write accepted = wr_en & !full; read accepted = rd_en & !empty.
  - A rejected request has no effect on data, pointers or count.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted; count unchanged.
  - Full: read only; count -> DEPTH-1.
  - Empty: write only, also in FWFT mode; count -> 1.
- Pointers: log2(DEPTH) bits each, increment on acceptance, wrap naturally from DEPTH-1 to 0.
- count: updated at the same edge as the accepted operation (+1, -1 or 0).
- Status outputs:
  - full, empty, almost_full and almost_empty are pure functions of registered count.
  - No combinational path from wr_en or rd_en to any status output.
- Standard mode (FWFT=0):
  - A read accepted at edge N loads dout with mem[rd_ptr] at edge N; the value is valid from N until the next accepted read.
  - dout holds its value otherwise, including across rejected reads.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] whenever empty=0 (combinational array read); rd_en pops the head word.
  - A write to an empty FIFO at edge N gives empty=0 and dout=din after N.
  - dout is don't-care while empty=1.
- Error flags:
  - wr_en & full at an edge sets overflow; rd_en & empty at an edge sets underflow.
  - Both flags stay set until err_clr or rst. If err_clr and a new error event occur at the same edge, the flag ends set.
- Data ordering: strict FIFO order; no drop or duplication across pointer wrap.
- Parameter violations are caught by an elaboration-time check in simulation: DEPTH not a power of two, or a threshold out of range.

Test Plan:
(Defaults unless stated: DATA_W=16, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2.)
1. Fill and drain:
   - Stimulus: after reset, wr_en=1 for 20 cycles with din=0..19.
   - Required: almost_empty drops after the 3rd write; almost_full rises after the 14th; full=1 and count=16 after the 16th; overflow=1 after the 17th.
   - Then rd_en=1 for 16 cycles: dout=0..15 in order, empty=1 and count=0 after the last read, underflow stays 0.
2. Pointer wrap:
   - Stimulus: write 10 words, read 10, then write 12 words 0x0100..0x010B and read 12.
   - Required: dout=0x0100..0x010B in order; count returns to 0.
3. Simultaneous at boundaries:
   - When full with wr_en=rd_en=1 for one cycle: count 16->15 and the new din is not stored.
   - When empty with both asserted: count 0->1 and dout unchanged in standard mode.
   - At count=5 with both asserted: count stays 5.
4. FWFT (FWFT=1):
   - Stimulus: write 0xA5A5 into an empty FIFO.
   - Required: next cycle empty=0 and dout=0xA5A5 with rd_en=0.
   - Then one rd_en cycle: empty=1, count=0.
5. Reset mid-operation:
   - Stimulus: write 5 words, then assert rst for one cycle with wr_en=1 and din=0xFFFF.
   - Required: count=0, empty=1, dout=0, flags cleared, 0xFFFF not stored.
   - Then write 0x0033 and read: dout=0x0033.
6. Underflow and clear:
   - Stimulus: rd_en=1 while empty.
   - Required: underflow=1, count stays 0, dout unchanged.
   - Pulse err_clr: underflow=0.
   - err_clr and rd_en together while empty: underflow=1.
